// File: rtl/des_pkg.sv
// Shared DES tables, key-shift schedule and FSM encoding.
// Used by the encrypt and decrypt cores; bit 1 of every DES table is the MSB.
package des_pkg;

   localparam int NUM_ROUNDS = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2,
      60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6,
      64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1,
      59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5,
      63, 55, 47, 39, 31, 23, 15, 7};

   localparam int FP_T [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32,
      39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30,
      37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28,
      35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26,
      33, 1, 41,  9, 49, 17, 57, 25};

   localparam int E_T [48] = '{
      32,  1,  2,  3,  4,  5,
       4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13,
      12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21,
      20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29,
      28, 29, 30, 31, 32,  1};

   localparam int P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,
       1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,
      19, 13, 30,  6, 22, 11,  4, 25};

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32};

   // Row-major: index = {b1,b6} * 16 + b2..b5 of the 6-bit S-box input.
   localparam int SBOX [8][64] = '{
      '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
      '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
      '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
      '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
      '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
      '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
      '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
      '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

   localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   function automatic logic [63:0] ip_perm(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
      return y;
   endfunction

   function automatic logic [63:0] fp_perm(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
      return y;
   endfunction

   function automatic logic [47:0] e_exp(input logic [31:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
      return y;
   endfunction

   function automatic logic [31:0] p_perm(input logic [31:0] x);
      logic [31:0] y;
      y = '0;
      for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
      return y;
   endfunction

   function automatic logic [55:0] pc1_perm(input logic [63:0] x);
      logic [55:0] y;
      y = '0;
      for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
      return y;
   endfunction

   function automatic logic [47:0] pc2_perm(input logic [55:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
      return y;
   endfunction

endpackage

// File: rtl/des_f.sv
// DES round function f(R, K): expand, key mix, S-box substitution, P permutation.
// Purely combinational; shared by the encrypt and decrypt cores.
module des_f
   import des_pkg::*;
(
   input  logic [31:0] r_i,
   input  logic [47:0] k_i,
   output logic [31:0] f_o
);

   logic [47:0] x;
   logic [31:0] s_out;
   logic [5:0]  six;

   always_comb begin
      x     = e_exp(r_i) ^ k_i;
      s_out = '0;
      six   = '0;
      for (int s = 0; s < 8; s++) begin
         six = x[47-6*s -: 6];
         // Outer bits pick the row, inner four the column.
         s_out[31-4*s -: 4] = 4'(SBOX[s][{six[5], six[0], six[4:1]}]);
      end
      f_o = p_perm(s_out);
   end

endmodule

// File: rtl/des_encrypt.sv
// Iterative DES encryption core: one Feistel round per clock, result held
// with done until the consumer acknowledges it.
module des_encrypt
   import des_pkg::*;
#(
   parameter int NUM_ROUNDS = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] message,
   input  logic [63:0] DESkey,
   input  logic        enable,
   input  logic        ack,
   output logic [63:0] encrypted,
   output logic        done,
   output logic        busy
);

   state_t      state_q, state_d;
   logic [31:0] l_q, l_d, r_q, r_d;
   logic [27:0] c_q, c_d, d_q, d_d;
   logic [3:0]  rnd_q, rnd_d;
   logic [63:0] enc_q, enc_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;

   logic [63:0] ip_msg;
   logic [55:0] pc1_key;
   logic [27:0] c_rot, d_rot;
   logic [47:0] subkey;
   logic [31:0] f_out;

   assign ip_msg  = ip_perm(message);
   assign pc1_key = pc1_perm(DESkey);

   // Registers hold the previous round's C/D; rotate ahead of PC-2 for this round.
   always_comb begin
      if (SHIFT_T[rnd_q] == 1) begin
         c_rot = {c_q[26:0], c_q[27]};
         d_rot = {d_q[26:0], d_q[27]};
      end else begin
         c_rot = {c_q[25:0], c_q[27:26]};
         d_rot = {d_q[25:0], d_q[27:26]};
      end
   end

   assign subkey = pc2_perm({c_rot, d_rot});

   des_f u_f (
      .r_i (r_q),
      .k_i (subkey),
      .f_o (f_out)
   );

   always_comb begin
      state_d = state_q;
      l_d     = l_q;
      r_d     = r_q;
      c_d     = c_q;
      d_d     = d_q;
      rnd_d   = rnd_q;
      enc_d   = enc_q;
      done_d  = done_q;
      busy_d  = busy_q;
      unique case (state_q)
         IDLE: begin
            // ack must be low so a held ack cannot immediately restart.
            if (enable && !ack) begin
               l_d     = ip_msg[63:32];
               r_d     = ip_msg[31:0];
               c_d     = pc1_key[55:28];
               d_d     = pc1_key[27:0];
               rnd_d   = 4'd0;
               busy_d  = 1'b1;
               state_d = ROUND;
            end
         end
         ROUND: begin
            c_d   = c_rot;
            d_d   = d_rot;
            l_d   = r_q;
            r_d   = l_q ^ f_out;
            rnd_d = rnd_q + 4'd1;
            if (rnd_q == 4'(NUM_ROUNDS - 1)) begin
               // Final swap: output block is R16 || L16.
               enc_d   = fp_perm({l_q ^ f_out, r_q});
               done_d  = 1'b1;
               busy_d  = 1'b0;
               rnd_d   = rnd_q;
               state_d = DONE;
            end
         end
         DONE: begin
            if (ack) begin
               done_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         l_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         rnd_q   <= '0;
         enc_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         l_q     <= l_d;
         r_q     <= r_d;
         c_q     <= c_d;
         d_q     <= d_d;
         rnd_q   <= rnd_d;
         enc_q   <= enc_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign encrypted = enc_q;
   assign done      = done_q;
   assign busy      = busy_q;

endmodule

// File: doc/des_encrypt.md
Name: des_encrypt

Overview:
Iterative DES encryption core, one Feistel round per clock. It is the forward-direction counterpart of the decrypt block and shares its enable/done/ack handshake. It latches a 64-bit plaintext and a 64-bit key on start and produces the 64-bit ciphertext after 16 round cycles. The result is held with `done` until the consumer acknowledges it.

Parameters:
- NUM_ROUNDS, 16, Feistel rounds per block. Fixed at 16 for standard DES; other values are unsupported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- message  input  64  plaintext; bit 63 is DES bit 1.
- DESkey  input  64  key including parity bits; parity is ignored by PC-1.
- enable  input  1  start request, sampled in IDLE.
- ack  input  1  consumer acknowledge of the result.
- encrypted  output  64  ciphertext register.
- done  output  1  result valid; held until ack.
- busy  output  1  high while rounds are in progress.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, encrypted=0, done=0, busy=0, round counter=0, L/R/C/D registers=0.
- Reset asserted mid-operation aborts immediately. No partial result is ever flagged.
- State IDLE: on a rising edge with enable=1 and ack=0 (edge N):
  - L/R <= IP(message); C/D <= PC-1(DESkey); rnd <= 0; state <= ROUND; busy <= 1.
  - The ack=0 condition prevents a restart loop while ack is still held high.
- State ROUND, edges N+1..N+16, one round per edge:
  - C/D rotate left by 1 on rounds 0, 1, 8, 15 and by 2 on all other rounds.
  - Subkey K = PC-2(rotated C/D).
  - L <= R; R <= L xor f(R, K); rnd <= rnd+1.
- Edge N+16 (rnd=15):
  - encrypted <= FP(R16 || L16), i.e. halves swapped before FP.
  - done <= 1; busy <= 0; state <= DONE.
  - Latency: done is visible 16 cycles after the start edge.
- State DONE: encrypted and done are held stable.
  - On an edge with ack=1: done <= 0; state <= IDLE.
  - encrypted keeps its value until the next completion.
- Inputs are sampled only at the start edge. Changes to message/DESkey during ROUND/DONE have no effect.
- enable during ROUND or DONE is ignored; there is no queueing.
- ack during IDLE or ROUND is ignored.
- ack and enable both high in DONE: go to IDLE only. A new start requires ack=0 on a later edge.
- Round counter is 4 bits, wrap-free: it exits at 15 and is cleared on start.
- f function: E-expansion 32->48, xor K, eight S-boxes 6->4, then P permutation 32->32. Purely combinational.

Decomposition:
- Package des_pkg holds:
  - IP, FP, E, P, PC-1 and PC-2 tables.
  - The 8 S-box tables.
  - The 16-entry left-shift schedule.
  - State encoding constants IDLE/ROUND/DONE.
- The package is shared with the decrypt block, which uses the same tables with the reversed schedule.
- One sub-module, des_f: combinational f(R[31:0], K[47:0]) -> [31:0]. It is reusable by decrypt.
- Top level holds the FSM, the key-schedule registers and the output register.

Test Plan:
- Key 133457799BBCDFF1, message 0123456789ABCDEF, enable=1 -> done rises exactly 16 cycles after the start edge, encrypted=85E813540F0AB405; busy high for those 16 cycles.
- Key 0000000000000000, message 0000000000000000 -> encrypted=8CA64DE9C1B123A7. Then ack=1 for 1 cycle -> done=0 the next cycle and encrypted unchanged.
- Key 0E329232EA6D0D73, message 8787878787878787 -> encrypted=0000000000000000. Change message and DESkey mid-ROUND -> result still 0000000000000000.
- Hold enable=1 and ack=1 through DONE -> FSM returns to IDLE with no restart. Drop ack with enable still 1 -> a new encryption starts and done reasserts 16 cycles later.
- Drive reset=0 asynchronously (between edges) at round 8 -> done=0, busy=0 and encrypted=0 immediately. After release, a fresh start gives the correct ciphertext.
- Loopback: feed encrypted into the decrypt block with the same key -> decrypted equals the original message for all three vectors above.
